// File: rtl/romix_ctrl_pkg.sv
// Shared types and defaults for the scrypt ROMix sequencer.
// Holds the X-state payload layout (X1 in the upper half, X0 in the lower
// half), the controller state encoding and default sizing parameters.
package romix_ctrl_pkg;

  localparam int unsigned DATA_W        = 1024;
  localparam int unsigned HALF_W        = 512;
  localparam int unsigned XADDR_W       = 10;
  localparam int unsigned DEF_N         = 1024;
  localparam int unsigned DEF_ADDR_W    = 10;
  localparam int unsigned DEF_SALSA_LAT = 8;

  // One 1024-bit ROMix state; x0 drives salsa B, x1 drives salsa Bx.
  typedef struct packed {
    logic [HALF_W-1:0] x1;
    logic [HALF_W-1:0] x0;
  } xstate_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH1  = 2'd1,
    ST_PH2  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/romix_ctrl.sv
// ROMix sequencer around an external fixed-latency salsa BlockMix core.
// Phase 1 stores V[k]=X then mixes, N times; phase 2 mixes, reads
// V[integerify(X)] and XORs it into X, finishing with a final mix.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   start                  request, accepted only when idle
//   data_in                initial X ([511:0]=X0, [1023:512]=X1)
//   busy, done, data_out   status, one-cycle completion pulse, final X
//   salsa_B, salsa_Bx      current X halves to the salsa core
//   salsa_Bo, salsa_X0     mixed X1/X0 from the salsa core
//   salsa_xaddr            integerify bits of the mixed X1
//   ram_we, ram_re         scratchpad strobes (sync RAM, 1-cycle read)
//   ram_addr, ram_wdata    scratchpad address and write data
//   ram_rdata              scratchpad read data
module romix_ctrl
  import romix_ctrl_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned SALSA_LAT = DEF_SALSA_LAT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_W-1:0]    data_in,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_W-1:0]    data_out,
  output logic [HALF_W-1:0]    salsa_B,
  output logic [HALF_W-1:0]    salsa_Bx,
  input  logic [HALF_W-1:0]    salsa_Bo,
  input  logic [HALF_W-1:0]    salsa_X0,
  input  logic [XADDR_W-1:0]   salsa_xaddr,
  output logic                 ram_we,
  output logic                 ram_re,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata
);

  localparam int unsigned K_W   = ADDR_W + 1;
  localparam int unsigned CYC_W = ($clog2(SALSA_LAT + 1) < 3) ? 3 : $clog2(SALSA_LAT + 1);

  localparam logic [K_W-1:0]   K_PH1_LAST   = K_W'(N - 1);
  localparam logic [K_W-1:0]   K_LAST       = K_W'(2 * N - 1);
  localparam logic [CYC_W-1:0] CYC_MIX_LAST = CYC_W'(SALSA_LAT - 1);
  localparam logic [CYC_W-1:0] CYC_XOR      = CYC_W'(SALSA_LAT);

  state_e            state_q, state_d;
  logic [K_W-1:0]    k_q;
  logic [CYC_W-1:0]  cyc_q;
  xstate_t           x_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] data_out_q;

  logic active, mix_end, xor_cyc, has_read, last_step;

  // Step decode: mix ends on cyc SALSA_LAT-1; read steps add one XOR cycle.
  assign active    = (state_q == ST_PH1) || (state_q == ST_PH2);
  assign mix_end   = active && (cyc_q == CYC_MIX_LAST);
  assign xor_cyc   = active && (cyc_q == CYC_XOR);
  assign has_read  = (k_q >= K_PH1_LAST) && (k_q != K_LAST);
  assign last_step = (k_q == K_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PH1;
      ST_PH1:  if (xor_cyc && (k_q == K_PH1_LAST)) state_d = ST_PH2;
      ST_PH2:  if (mix_end && last_step) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters, X state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q        <= '0;
      cyc_q      <= '0;
      x_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            x_q    <= xstate_t'(data_in);
            busy_q <= 1'b1;
            k_q    <= '0;
            cyc_q  <= '0;
          end
        end
        ST_PH1, ST_PH2: begin
          if (mix_end) begin
            x_q <= xstate_t'({salsa_Bo, salsa_X0});
            if (has_read) begin
              cyc_q <= CYC_XOR;
            end else begin
              cyc_q <= '0;
              if (last_step) begin
                data_out_q <= {salsa_Bo, salsa_X0};
                done_q     <= 1'b1;
              end else begin
                k_q <= k_q + K_W'(1);
              end
            end
          end else if (xor_cyc) begin
            // Read data for V[j] is valid the cycle after ram_re.
            x_q   <= xstate_t'(x_q ^ ram_rdata);
            cyc_q <= '0;
            k_q   <= k_q + K_W'(1);
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        ST_DONE: busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Scratchpad strobes decode straight from registers so reset drops them at once.
  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = '0;
    if ((state_q == ST_PH1) && (cyc_q == '0)) begin
      ram_we   = 1'b1;
      ram_addr = ADDR_W'(k_q);
    end else if (mix_end && has_read) begin
      ram_re   = 1'b1;
      ram_addr = ADDR_W'(salsa_xaddr);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign data_out  = data_out_q;
  assign salsa_B   = x_q.x0;
  assign salsa_Bx  = x_q.x1;
  assign ram_wdata = x_q;

endmodule

// File: tb/tb_romix_ctrl.sv
// Directed bench for romix_ctrl at N=4 with a pipelined stub salsa core
// (mixed output valid SALSA_LAT cycles after B/Bx settle) and a sync RAM.
// Expected timing is hand-derived; expected data comes from a loop-form
// ROMix model using the same stub mix function.
module tb_romix_ctrl;

  localparam int unsigned TN     = 4;
  localparam int unsigned TAW    = 2;
  localparam int unsigned TLAT   = 8;
  localparam int          BUDGET = 200;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [1023:0]   data_in;
  logic            busy, done;
  logic [1023:0]   data_out;
  logic [511:0]    salsa_B, salsa_Bx, salsa_Bo, salsa_X0;
  logic [9:0]      salsa_xaddr;
  logic            ram_we, ram_re;
  logic [TAW-1:0]  ram_addr;
  logic [1023:0]   ram_wdata;
  logic [1023:0]   ram_rdata = '0;

  logic            fixed_xaddr;
  logic [1023:0]   pipe [TLAT-1];
  logic [1023:0]   mem  [TN];

  int checks = 0;
  int errors = 0;
  int wr_cyc[$], wr_addr[$], rd_cyc[$], rd_addr[$], exp_rd[$];
  int both_cnt, done_at;
  logic busy_first, busy_after, done_after;

  always #5 clk = ~clk;

  romix_ctrl #(.N(TN), .ADDR_W(TAW), .SALSA_LAT(TLAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .busy(busy), .done(done), .data_out(data_out),
    .salsa_B(salsa_B), .salsa_Bx(salsa_Bx), .salsa_Bo(salsa_Bo),
    .salsa_X0(salsa_X0), .salsa_xaddr(salsa_xaddr),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Stub mix: returns {new X1, new X0}.
  function automatic logic [1023:0] mixf(input logic [1023:0] x);
    logic [511:0] x0, x1, n0, n1;
    x0 = x[511:0];
    x1 = x[1023:512];
    n1 = {x0[500:0], x0[511:501]} + x1;
    n0 = x1 ^ {16{32'h9E37_79B9}};
    return {n1, n0};
  endfunction

  // Stub salsa: TLAT-1 register stages; output settles before the sampling edge.
  always @(posedge clk) begin
    pipe[0] <= mixf({salsa_Bx, salsa_B});
    for (int i = 1; i < TLAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign salsa_Bo    = pipe[TLAT-2][1023:512];
  assign salsa_X0    = pipe[TLAT-2][511:0];
  assign salsa_xaddr = fixed_xaddr ? 10'h3FF : pipe[TLAT-2][521:512];

  // Synchronous scratchpad.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (low 128 bits)", tag, got[127:0], exp[127:0]);
    end
  endtask

  // Reference ROMix in loop form; also records expected read addresses.
  task automatic model(input logic [1023:0] din, input bit fixed, output logic [1023:0] dout);
    logic [1023:0] v [TN];
    logic [1023:0] x;
    int j;
    exp_rd.delete();
    x = din;
    for (int i = 0; i < TN; i++) begin
      v[i] = x;
      x = mixf(x);
    end
    for (int i = 0; i < TN; i++) begin
      j = fixed ? TN - 1 : int'(x[512 +: TAW]);
      exp_rd.push_back(j);
      x = mixf(x ^ v[j]);
    end
    dout = x;
  endtask

  // Start one operation and sample once per cycle; c=1 is the cycle after the accepting edge.
  task automatic run_op(input logic [1023:0] din, input int poke_a, input int poke_b,
                        input int abort_at);
    wr_cyc.delete(); wr_addr.delete(); rd_cyc.delete(); rd_addr.delete();
    both_cnt = 0; done_at = -1; busy_first = 1'b0; busy_after = 1'b1; done_after = 1'b1;
    @(negedge clk);
    data_in = din;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      if (c == 1) busy_first = busy;
      if (ram_we) begin wr_cyc.push_back(c); wr_addr.push_back(int'(ram_addr)); end
      if (ram_re) begin rd_cyc.push_back(c); rd_addr.push_back(int'(ram_addr)); end
      if (ram_we && ram_re) both_cnt++;
      if (c == abort_at) begin
        chk("abort_re_before", 1024'(ram_re), 1024'(1));
        chk("abort_busy_before", 1024'(busy), 1024'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 1024'(busy), 1024'(0));
        chk("abort_re", 1024'(ram_re), 1024'(0));
        chk("abort_we", 1024'(ram_we), 1024'(0));
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        done_at = c;
        @(negedge clk);
        busy_after = busy;
        done_after = done;
        break;
      end
      start = (c == poke_a) || (c == poke_b);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Checks common to every complete run.
  task automatic chk_run(input string tag, input logic [1023:0] exp_out, input bit fixed);
    chk({tag, "_done_at"}, 1024'(done_at), 1024'(69));
    chk({tag, "_data_out"}, data_out, exp_out);
    chk({tag, "_busy_c1"}, 1024'(busy_first), 1024'(1));
    chk({tag, "_busy_after"}, 1024'(busy_after), 1024'(0));
    chk({tag, "_done_pulse"}, 1024'(done_after), 1024'(0));
    chk({tag, "_we_re_both"}, 1024'(both_cnt), 1024'(0));
    chk({tag, "_wr_count"}, 1024'(wr_cyc.size()), 1024'(TN));
    for (int i = 0; i < TN; i++) begin
      chk({tag, "_wr_cyc"}, 1024'(i < wr_cyc.size() ? wr_cyc[i] : -1), 1024'(1 + 8 * i));
      chk({tag, "_wr_addr"}, 1024'(i < wr_addr.size() ? wr_addr[i] : -1), 1024'(i));
    end
    chk({tag, "_rd_count"}, 1024'(rd_cyc.size()), 1024'(TN));
    for (int i = 0; i < TN; i++) begin
      // Reads land at c=32,41,50,59 (k=3..6, cyc 7 of 9-cycle steps).
      chk({tag, "_rd_cyc"}, 1024'(i < rd_cyc.size() ? rd_cyc[i] : -1), 1024'(32 + 9 * i));
      chk({tag, "_rd_addr"}, 1024'(i < rd_addr.size() ? rd_addr[i] : -1),
          1024'(fixed ? 3 : exp_rd[i]));
    end
  endtask

  initial begin
    logic [1023:0] din_a, din_b, din_c, exp_a, exp_b, exp_c;
    int quiet;
    din_a = {16{64'hDEAD_BEEF_0123_4567}};
    din_b = {32{32'hF0E1_D2C3}} ^ {1000'd0, 24'hABCDEF};
    din_c = {64{16'h5A3C}} + {512'd0, 512'h1234_5678_9ABC_DEF0};

    // Reset with arbitrary inputs: everything must read as zero.
    rst_n = 1'b0;
    fixed_xaddr = 1'b0;
    for (int i = 0; i < 32; i++) data_in[i*32 +: 32] = $urandom();
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 1024'(busy), 1024'(0));
    chk("rst_done", 1024'(done), 1024'(0));
    chk("rst_data_out", data_out, 1024'(0));
    chk("rst_salsa_B", 1024'(salsa_B), 1024'(0));
    chk("rst_salsa_Bx", 1024'(salsa_Bx), 1024'(0));
    chk("rst_we_re", 1024'({ram_we, ram_re}), 1024'(0));
    chk("rst_addr", 1024'(ram_addr), 1024'(0));
    chk("rst_wdata", ram_wdata, 1024'(0));
    start = 1'b0;
    rst_n = 1'b1;
    quiet = 0;
    repeat (4) begin
      @(negedge clk);
      if (ram_we || ram_re || busy) quiet++;
    end
    chk("idle_quiet", 1024'(quiet), 1024'(0));

    // Normal run: integerify addresses follow the mixed state.
    model(din_a, 1'b0, exp_a);
    run_op(din_a, 0, 0, 0);
    chk_run("norm", exp_a, 1'b0);

    // Forced xaddr=0x3FF: every read hits V[3].
    fixed_xaddr = 1'b1;
    model(din_b, 1'b1, exp_b);
    run_op(din_b, 0, 0, 0);
    chk_run("fixed", exp_b, 1'b1);

    // start pulses while busy are ignored.
    fixed_xaddr = 1'b0;
    model(din_a, 1'b0, exp_a);
    run_op(din_a, 10, 40, 0);
    chk_run("busy_start", exp_a, 1'b0);

    // Reset during the PH2 read at c=41, then a clean full run.
    run_op(din_b, 0, 0, 41);
    chk("abort_data_out", data_out, 1024'(0));
    model(din_c, 1'b0, exp_c);
    run_op(din_c, 0, 0, 0);
    chk_run("after_rst", exp_c, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
